div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Iterative radix-2 divider for the RV32M DIV/DIVU/REM/REMU instructions, in the execute stage beside the single-cycle ALU.
- Execute launches it with a start pulse and stalls on busy.
- It returns a 32-bit result with a one-cycle done pulse, and that result is muxed into the execute result path in place of the ALU output.
- It replaces combinational division with a 33-cycle sequential datapath.

Parameters:
- XLEN, 32, operand/result width; only 32 is required to be supported.
- ITERS, XLEN, quotient bits resolved per operation (one per CALC cycle).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  launch request; sampled only in IDLE.
- op  input  2  00=DIV, 01=DIVU, 10=REM, 11=REMU.
- operand_a  input  XLEN  dividend (rs1).
- operand_b  input  XLEN  divisor (rs2).
- flush  input  1  synchronous abort from pipeline flush (branch/trap).
- busy  output  1  high while state is CALC.
- done  output  1  one-cycle pulse; result valid this cycle.
- result  output  XLEN  quotient or remainder.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, result=0, all internal registers 0. Reset applies immediately, including mid-operation; no done is produced for the aborted operation.
- States: IDLE, CALC, DONE.
- IDLE & start & !flush: latch op and operands. Signed ops (DIV/REM) take magnitudes and record neg_q = sign(a)^sign(b) and neg_r = sign(a). Unsigned ops set neg_q = neg_r = 0.
- Special cases, decided in the start cycle; next state is DONE directly:
  - operand_b==0: DIV/DIVU result = 0xFFFFFFFF; REM/REMU result = operand_a.
  - DIV with a=0x80000000, b=0xFFFFFFFF: result 0x80000000.
  - REM with a=0x80000000, b=0xFFFFFFFF: result 0.
- Otherwise the next state is CALC with count=0, remainder accumulator=0, and quotient register = |a|.
- CALC, one restoring step per cycle:
  - Shift {rem,quo} left 1.
  - Trial-subtract |b| from the upper half using XLEN+1-bit arithmetic.
  - If the difference is non-negative, keep it and set quo[0]=1; else restore.
  - count increments each cycle.
  - After ITERS cycles, result is registered as quotient (DIV/DIVU) or remainder (REM/REMU), two's-complement negated when neg_q or neg_r respectively applies. Next state is DONE.
- DONE: done=1 for exactly this cycle. Next state is IDLE unconditionally. start is ignored in DONE.
- Latency: start sampled at edge 0; normal op gives done high during cycle 33 (32 CALC + 1 DONE); special case gives done high during cycle 1.
- result holds its value from done until the next completed operation. It never changes mid-CALC on the output port.
- start while busy or in DONE: ignored. Operands are not re-sampled; operands changing during CALC have no effect.
- flush (synchronous, highest priority after reset): any state goes to IDLE next cycle with busy=0, done suppressed, and result unchanged. flush together with start in IDLE means start is ignored.
- Arithmetic: magnitude of 0x80000000 is 0x80000000 treated as unsigned; internal datapath is unsigned XLEN bits plus 1 guard bit. No X propagation: unused op encodings do not exist (2-bit op fully decoded).

Test Plan:
- DIV a=0xFFFFFFF9 (-7), b=2 -> done at cycle 33, result=0xFFFFFFFD (-3). Repeat with REM -> result=0xFFFFFFFF (-1).
- DIVU a=0xFFFFFFFF, b=0x10 -> result=0x0FFFFFFF. REMU same operands -> 0x0000000F. busy high cycles 1-32, done only at cycle 33.
- Divide-by-zero: DIV 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 0x00000005, both with done at cycle 1 and busy never asserted.
- Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at cycle 1. REM same operands -> 0x00000000.
- Abort paths:
  - Flush at cycle 10 of a DIVU 100/7 -> IDLE at cycle 11, no done, result retains prior value.
  - Immediately relaunch DIVU 100/7 -> result 0x0000000E at done.
  - Assert rst_n=0 mid-CALC -> busy/done/result 0 asynchronously.
- Ignored start: pulse start with new operands at cycles 5 and 33 during a REM 0xFFFFFF9C (-100)/7 op -> single done, result=0xFFFFFFFE (-2). Next IDLE start proceeds normally.

Source files
------------

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per CALC cycle; divide-by-zero and signed overflow
// are resolved in the launch cycle and skip straight to DONE.
module div_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned ITERS = XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned     CW   = $clog2(ITERS) + 1;
  localparam logic [CW-1:0]   LAST = CW'(ITERS - 1);
  localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic            is_rem, neg_q, neg_r;
  logic [XLEN-1:0] dvsr, rem, quo, res_q;
  logic [CW-1:0]   count;

  // launch-cycle decode
  logic            sgn, a_neg, b_neg, div_zero, ovf, special, launch;
  logic [XLEN-1:0] a_mag, b_mag, special_res;

  // one restoring step
  logic [XLEN:0]   rem_sh, diff;
  logic            take;
  logic [XLEN-1:0] rem_nxt, quo_nxt, q_out, r_out, fin_res;

  // Operand magnitudes, sign bookkeeping and special-case results at launch
  always_comb begin
    sgn         = ~op[0];
    a_neg       = sgn & operand_a[XLEN-1];
    b_neg       = sgn & operand_b[XLEN-1];
    a_mag       = a_neg ? ('0 - operand_a) : operand_a;
    b_mag       = b_neg ? ('0 - operand_b) : operand_b;
    div_zero    = (operand_b == '0);
    ovf         = sgn & (operand_a == MINV) & (operand_b == '1);
    special     = div_zero | ovf;
    special_res = '0;
    if (div_zero) begin
      special_res = op[1] ? operand_a : '1;
    end else if (ovf) begin
      special_res = op[1] ? '0 : MINV;
    end
    launch      = (state == S_IDLE) & start & ~flush;
  end

  // Shift {rem,quo} left, trial-subtract the divisor with a guard bit, restore on borrow
  always_comb begin
    rem_sh  = {rem, quo[XLEN-1]};
    diff    = rem_sh - {1'b0, dvsr};
    take    = ~diff[XLEN];
    rem_nxt = take ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_nxt = {quo[XLEN-2:0], take};
    q_out   = neg_q ? ('0 - quo_nxt) : quo_nxt;
    r_out   = neg_r ? ('0 - rem_nxt) : rem_nxt;
    fin_res = is_rem ? r_out : q_out;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; flush overrides everything but reset
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:  if (start) state_nxt = special ? S_DONE : S_CALC;
        S_CALC:  if (count == LAST) state_nxt = S_DONE;
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath registers; result only updates on the final step or a special case
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_rem <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dvsr   <= '0;
      rem    <= '0;
      quo    <= '0;
      count  <= '0;
      res_q  <= '0;
    end else if (launch) begin
      is_rem <= op[1];
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      dvsr   <= b_mag;
      if (special) begin
        res_q <= special_res;
      end else begin
        rem   <= '0;
        quo   <= a_mag;
        count <= '0;
      end
    end else if (state == S_CALC && !flush) begin
      rem   <= rem_nxt;
      quo   <= quo_nxt;
      count <= count + 1'b1;
      if (count == LAST) res_q <= fin_res;
    end
  end

  assign busy   = (state == S_CALC);
  assign done   = (state == S_DONE);
  assign result = res_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected results are queued at launch
// and compared when done is observed, along with latency and busy shape.
module tb_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res = '0;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  div_unit #(.XLEN(32), .ITERS(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model built on native signed arithmetic
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'h0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : 32'h8000_0000;
    case (o)
      OP_DIV:  return sa / sb;
      OP_DIVU: return a / b;
      OP_REM:  return sa % sb;
      default: return a % b;
    endcase
  endfunction

  function automatic int lat_of(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'h0) return 1;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    bit seen;
    logic eb;
    logic [31:0] e;
    seen = 0;
    @(negedge clk);
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    exp_q.push_back(exp);
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      eb = (c < exp_lat);
      checks++;
      if (busy !== eb) begin
        errors++;
        $display("FAIL %s busy cycle %0d: got %b want %b", name, c, busy, eb);
      end
      if (done === 1'b1) begin
        seen = 1;
        checks++;
        if (c != exp_lat) begin
          errors++;
          $display("FAIL %s latency: got %0d want %0d", name, c, exp_lat);
        end
        e = exp_q.pop_front();
        checks++;
        if (result !== e) begin
          errors++;
          $display("FAIL %s result: got %h want %h", name, result, e);
        end
        last_res = e;
      end
    end
    start = 1'b0;
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s timeout: got no done want done at %0d", name, exp_lat);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s pulse: got done=%b busy=%b want 0/0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; operand_a = '0; operand_b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", done); end
    checks++;
    if (result !== 32'h0) begin errors++; $display("FAIL reset result: got %h want 0", result); end
    @(negedge clk);
    rst_n = 1'b1;
    last_res = '0;
  endtask

  task automatic test_signed();
    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 33);
    run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 33);
  endtask

  task automatic test_unsigned();
    run_op("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 33);
    run_op("remu_big", OP_REMU, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, 33);
  endtask

  task automatic test_div_zero();
    run_op("div_by0",  OP_DIV,  32'h5, 32'h0, 32'hFFFF_FFFF, 1);
    run_op("remu_by0", OP_REMU, 32'h5, 32'h0, 32'h0000_0005, 1);
  endtask

  task automatic test_overflow();
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
  endtask

  task automatic test_flush();
    logic [31:0] prev;
    bit got_done;
    prev = last_res;
    got_done = 0;
    @(negedge clk);
    op = OP_DIVU; operand_a = 32'd100; operand_b = 32'd7; start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (done === 1'b1) got_done = 1;
      if (c == 10) flush = 1'b1;
    end
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush busy: got %b want 0", busy); end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) got_done = 1;
    end
    checks++;
    if (got_done) begin errors++; $display("FAIL flush done: got 1 want 0"); end
    checks++;
    if (result !== prev) begin errors++; $display("FAIL flush result: got %h want %h", result, prev); end
    run_op("relaunch", OP_DIVU, 32'd100, 32'd7, 32'h0000_000E, 33);
  endtask

  task automatic test_ignored_start();
    int ndone;
    int at;
    logic [31:0] e;
    ndone = 0; at = 0;
    @(negedge clk);
    op = OP_REM; operand_a = 32'hFFFF_FF9C; operand_b = 32'd7; start = 1'b1;
    exp_q.push_back(32'hFFFF_FFFE);
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        at = c;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checks++;
          if (result !== e) begin errors++; $display("FAIL ign_start result: got %h want %h", result, e); end
          last_res = e;
        end
      end
      start = 1'b0;
      if (c == 5 || c == 33) begin
        start = 1'b1; op = OP_DIVU; operand_a = $urandom; operand_b = 32'd3;
      end
    end
    start = 1'b0;
    checks++;
    if (ndone != 1) begin errors++; $display("FAIL ign_start count: got %0d want 1", ndone); end
    checks++;
    if (at != 33) begin errors++; $display("FAIL ign_start cycle: got %0d want 33", at); end
    run_op("after_ign", OP_REMU, 32'hFFFF_FF9C, 32'd7, model(OP_REMU, 32'hFFFF_FF9C, 32'd7), 33);
  endtask

  task automatic test_async_reset();
    bit got_done;
    got_done = 0;
    @(negedge clk);
    op = OP_DIVU; operand_a = 32'h1234_5678; operand_b = 32'd3; start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL async_rst outputs: got busy=%b done=%b result=%h want 0/0/0", busy, done, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_res = '0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) got_done = 1;
    end
    checks++;
    if (got_done || result !== 32'h0) begin
      errors++;
      $display("FAIL async_rst after: got done=%b result=%h want 0/0", got_done, result);
    end
    run_op("post_rst", OP_DIV, 32'd1000, 32'hFFFF_FFF6, 32'hFFFF_FF9C, 33);
  endtask

  task automatic test_back_to_back();
    logic [1:0]  o;
    logic [31:0] a, b;
    for (int i = 0; i < 10; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'($urandom_range(0, 20));
        1:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if (i == 3) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (i == 4) b = 32'h0;
      run_op("random", o, a, b, model(o, a, b), lat_of(o, a, b));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_signed();
    test_unsigned();
    test_div_zero();
    test_overflow();
    test_flush();
    test_ignored_start();
    test_async_reset();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
